mem_bus_arbiter: RTL and testbench

Two-port to one-port arbiter sharing a single SRAM-like memory bus between the fetch stage (instruction port, read-only) and the memory stage (data port, read/write). Accepts at most one transaction at a time, latches it, drives it onto the shared bus, and routes the response back to the originating port. Sits between the core's `i_*`/`d_*` request ports and the external bus bridge.

---
 rtl/mem_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch (i_*) and data (d_*) ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              grant_i;
    logic              grant_d;
    logic              accept;
    logic              done;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_pref_d = 1 means data is preferred on the next tie; flips to the loser on every grant
    logic rr_pref_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_pref_d <= 1'b0;
        end else if (accept) begin
            rr_pref_d <= grant_i;
        end
    end

    assign grant_d = d_req && (!i_req || rr_pref_d);
`else
    assign grant_d = d_req;
`endif

    assign grant_i = i_req && !grant_d;

    // Gated by resetn so no grant leaks out combinationally while reset is held
    assign accept    = resetn && (state == S_IDLE) && (grant_i || grant_d);
    assign i_addr_ok = accept && grant_i;
    assign d_addr_ok = accept && grant_d;

    assign done      = ((state == S_REQ) && bus_addr_ok && bus_data_ok) ||
                       ((state == S_WAIT) && bus_data_ok);
    assign i_data_ok = done && !owner;
    assign d_data_ok = done && owner;

    assign i_rdata   = bus_rdata;
    assign d_rdata   = bus_rdata;

    assign bus_req   = (state == S_REQ);
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_addr_ok) begin
                    state_nxt = bus_data_ok ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            owner   <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner   <= grant_d;
                wr_q    <= grant_d ? d_wr : 1'b0;
                size_q  <= grant_d ? d_size : 2'd2;
                addr_q  <= grant_d ? d_addr : i_addr;
                wdata_q <= grant_d ? d_wdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; inputs change on the falling edge, outputs checked 1ns later.
// Contention expectations follow ARB_ROUND_ROBIN_EN as the RTL is built.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        logic exp_first_d;
        logic exp_d;

        resetn = 1'b0;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h0000_0200; d_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

        // Reset held with both requests high
        step; step; #1;
        chk("rst_i_addr_ok", i_addr_ok, 0);
        chk("rst_d_addr_ok", d_addr_ok, 0);
        chk("rst_bus_req",   bus_req,   0);
        chk("rst_bus_wr",    bus_wr,    0);
        chk("rst_bus_size",  bus_size,  0);
        chk("rst_bus_addr",  bus_addr,  0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_i_data_ok", i_data_ok, 0);
        chk("rst_d_data_ok", d_data_ok, 0);

`ifdef ARB_ROUND_ROBIN_EN
        exp_first_d = 1'b0;
`else
        exp_first_d = 1'b1;
`endif
        // First IDLE cycle after release grants immediately
        step; resetn = 1'b1; #1;
        chk("rel_i_addr_ok", i_addr_ok, !exp_first_d);
        chk("rel_d_addr_ok", d_addr_ok, exp_first_d);
        step; i_req = 1'b0; d_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
        chk("rel_bus_req",   bus_req,   1);
        chk("rel_bus_addr",  bus_addr,  exp_first_d ? 32'h0000_0200 : 32'h0000_0100);
        chk("rel_i_data_ok", i_data_ok, !exp_first_d);
        chk("rel_d_data_ok", d_data_ok, exp_first_d);
        step; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        chk("rel_idle_bus_req", bus_req, 0);

        // Single fetch: bus addr_ok in cycle 3, data_ok in cycle 6
        step; i_req = 1'b1; i_addr = 32'hBFC0_0000; #1;
        chk("f0_i_addr_ok", i_addr_ok, 1);
        chk("f0_d_addr_ok", d_addr_ok, 0);
        step; i_req = 1'b0; #1;
        chk("f1_bus_req",  bus_req,  1);
        chk("f1_bus_addr", bus_addr, 32'hBFC0_0000);
        chk("f1_bus_wr",   bus_wr,   0);
        chk("f1_bus_size", bus_size, 2);
        chk("f1_i_addr_ok", i_addr_ok, 0);
        step; #1;
        chk("f2_bus_req",  bus_req,  1);
        chk("f2_bus_addr", bus_addr, 32'hBFC0_0000);
        step; bus_addr_ok = 1'b1; #1;
        chk("f3_bus_req",   bus_req,   1);
        chk("f3_i_data_ok", i_data_ok, 0);
        step; bus_addr_ok = 1'b0; #1;
        chk("f4_bus_req",   bus_req,   0);
        step; #1;
        chk("f5_i_data_ok", i_data_ok, 0);
        step; bus_data_ok = 1'b1; bus_rdata = 32'h3C08_0001; #1;
        chk("f6_i_data_ok", i_data_ok, 1);
        chk("f6_i_rdata",   i_rdata,   32'h3C08_0001);
        chk("f6_d_data_ok", d_data_ok, 0);
        chk("f6_d_rdata",   d_rdata,   32'h3C08_0001);
        step; bus_data_ok = 1'b0; #1;
        chk("f7_i_data_ok", i_data_ok, 0);

        // Spurious bus_data_ok while IDLE
        step; bus_data_ok = 1'b1; #1;
        chk("sp_idle_i_data_ok", i_data_ok, 0);
        chk("sp_idle_d_data_ok", d_data_ok, 0);
        step; bus_data_ok = 1'b0; #1;
        chk("sp_idle_bus_req", bus_req, 0);

        // Data write, with a spurious data_ok in REQ first
        step; d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = 32'h8000_1003; d_wdata = 32'h0000_00AA; #1;
        chk("w0_d_addr_ok", d_addr_ok, 1);
        chk("w0_i_addr_ok", i_addr_ok, 0);
        step; d_req = 1'b0; bus_data_ok = 1'b1; #1;
        chk("w1_bus_req",   bus_req,   1);
        chk("w1_bus_wr",    bus_wr,    1);
        chk("w1_bus_size",  bus_size,  0);
        chk("w1_bus_addr",  bus_addr,  32'h8000_1003);
        chk("w1_bus_wdata", bus_wdata, 32'h0000_00AA);
        chk("w1_d_data_ok", d_data_ok, 0);
        step; bus_addr_ok = 1'b1; #1;
        chk("w2_bus_req",   bus_req,   1);
        chk("w2_d_data_ok", d_data_ok, 1);
        chk("w2_i_data_ok", i_data_ok, 0);
        step; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        chk("w3_bus_req",   bus_req,   0);
        chk("w3_d_data_ok", d_data_ok, 0);

        // Contention: both held for four transactions, each completing in one bus cycle
        i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_wr = 1'b0; d_size = 2'd2;
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (t % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            step; i_req = 1'b1; d_req = 1'b1; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
            chk($sformatf("c%0d_i_addr_ok", t), i_addr_ok, !exp_d);
            chk($sformatf("c%0d_d_addr_ok", t), d_addr_ok, exp_d);
            step; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
            chk($sformatf("c%0d_busy_addr_ok", t), {i_addr_ok, d_addr_ok}, 0);
            chk($sformatf("c%0d_bus_addr", t), bus_addr, exp_d ? 32'h0000_0200 : 32'h0000_0100);
            chk($sformatf("c%0d_d_data_ok", t), d_data_ok, exp_d);
            chk($sformatf("c%0d_i_data_ok", t), i_data_ok, !exp_d);
        end
        // Fetch wins once data drops its request
        step; d_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        chk("c_end_i_addr_ok", i_addr_ok, 1);
        chk("c_end_d_addr_ok", d_addr_ok, 0);
        step; i_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
        chk("c_end_i_data_ok", i_data_ok, 1);
        step; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

        // Mid-transaction reset while in WAIT
        step; d_req = 1'b1; d_addr = 32'h0000_0300; #1;
        chk("mr_d_addr_ok", d_addr_ok, 1);
        step; d_req = 1'b0; bus_addr_ok = 1'b1; #1;
        chk("mr_bus_req", bus_req, 1);
        step; bus_addr_ok = 1'b0; #1;
        chk("mr_wait_bus_req", bus_req, 0);
        step; resetn = 1'b0; #1;
        chk("mr_rst_bus_addr", bus_addr, 0);
        chk("mr_rst_bus_req",  bus_req,  0);
        step; resetn = 1'b1; bus_data_ok = 1'b1; #1;
        chk("mr_late_d_data_ok", d_data_ok, 0);
        chk("mr_late_i_data_ok", i_data_ok, 0);
        step; bus_data_ok = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0400; #1;
        chk("mr_next_d_addr_ok", d_addr_ok, 1);
        step; d_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
        chk("mr_next_bus_addr",  bus_addr,  32'h0000_0400);
        chk("mr_next_d_data_ok", d_data_ok, 1);
        step; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        chk("mr_done_bus_req", bus_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
